// File: rtl/decode_issue_queue_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : decode_issue_queue_pkg                                      |
// | Purpose  : Shared definitions for the decode/issue queue: RV32I opcode |
// |            and funct tags, the operator enum (including ILLEGAL), the  |
// |            queue slot record and the reserved zero register/ROB tags.  |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package decode_issue_queue_pkg;

  localparam int ZERO_ROB = 0;
  localparam logic [4:0] ZERO_REG = 5'd0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND,
    OP_ILLEGAL
  } op_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        predict;
  } iq_entry_t;

endpackage
`default_nettype wire

// File: rtl/decode_issue_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : decode_issue_queue_if                                       |
// | Purpose  : Bundles the fetch, backend-status and dispatch signals of   |
// |            the decode/issue queue.                                     |
// |            master : environment side (drives in_*, reads out_*)        |
// |            slave  : queue side       (reads in_*, drives out_*)        |
// | Ports    : none (signals listed below)                                 |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface decode_issue_queue_if #(
  parameter int ROB_IDX_W = 4,
  parameter int OP_W      = 6
);
  logic                 rdy_in;
  logic                 in_flush;
  logic                 in_fetch_valid;
  logic [31:0]          in_fetch_inst;
  logic [31:0]          in_fetch_pc;
  logic                 in_fetch_predict;
  logic                 out_fetch_full;
  logic                 in_rob_full;
  logic                 in_rs_full;
  logic                 in_lsb_full;
  logic [ROB_IDX_W-1:0] in_rob_tail;
  logic                 out_rob_assign_enable;
  logic                 out_rs_assign_enable;
  logic                 out_lsb_assign_enable;
  logic                 out_reg_write_enable;
  logic [OP_W-1:0]      out_type;
  logic [31:0]          out_imm;
  logic [31:0]          out_pc;
  logic                 out_predict;
  logic [4:0]           out_rd;
  logic [4:0]           out_rs;
  logic [4:0]           out_rt;
  logic [ROB_IDX_W-1:0] out_reorder;
  logic                 out_illegal;

  modport master (
    output rdy_in, in_flush, in_fetch_valid, in_fetch_inst, in_fetch_pc,
           in_fetch_predict, in_rob_full, in_rs_full, in_lsb_full, in_rob_tail,
    input  out_fetch_full, out_rob_assign_enable, out_rs_assign_enable,
           out_lsb_assign_enable, out_reg_write_enable, out_type, out_imm,
           out_pc, out_predict, out_rd, out_rs, out_rt, out_reorder, out_illegal
  );

  modport slave (
    input  rdy_in, in_flush, in_fetch_valid, in_fetch_inst, in_fetch_pc,
           in_fetch_predict, in_rob_full, in_rs_full, in_lsb_full, in_rob_tail,
    output out_fetch_full, out_rob_assign_enable, out_rs_assign_enable,
           out_lsb_assign_enable, out_reg_write_enable, out_type, out_imm,
           out_pc, out_predict, out_rd, out_rs, out_rt, out_reorder, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/decode_issue_queue_inst_field_decode.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : inst_field_decode                                           |
// | Purpose  : Combinational RV32I field decoder: operator, immediate,     |
// |            register indices, load/store flag, rd-write flag, illegal.  |
// | Ports    : i_inst (32) in; o_type, o_imm, o_rd/o_rs/o_rt, o_is_ls,     |
// |            o_writes_rd, o_illegal out.                                 |
// | Config   : DECODE_ILLEGAL_TRAP_EN - report unknown encodings as        |
// |            ILLEGAL; otherwise they decode as ADDI x0,x0,0.             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module inst_field_decode
  import decode_issue_queue_pkg::*;
(
  input  logic [31:0] i_inst,
  output op_e         o_type,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic        o_is_ls,
  output logic        o_writes_rd,
  output logic        o_illegal
);
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
  op_e         w_type;
  logic [31:0] w_imm;
  logic        w_bad;

  assign w_opc    = i_inst[6:0];
  assign w_f3     = i_inst[14:12];
  assign w_f7     = i_inst[31:25];
  assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u  = {i_inst[31:12], 12'b0};
  assign w_imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign w_imm_sh = {27'b0, i_inst[24:20]};

  // Every legal path clears w_bad; any unmatched funct falls back to ILLEGAL.
  always_comb begin
    w_type = OP_ILLEGAL;
    w_imm  = '0;
    w_bad  = 1'b1;
    case (w_opc)
      OPC_LUI:   begin w_type = OP_LUI;   w_imm = w_imm_u; w_bad = 1'b0; end
      OPC_AUIPC: begin w_type = OP_AUIPC; w_imm = w_imm_u; w_bad = 1'b0; end
      OPC_JAL:   begin w_type = OP_JAL;   w_imm = w_imm_j; w_bad = 1'b0; end
      OPC_JALR: if (w_f3 == 3'd0) begin
        w_type = OP_JALR; w_imm = w_imm_i; w_bad = 1'b0;
      end
      OPC_BRANCH: begin
        w_imm = w_imm_b; w_bad = 1'b0;
        case (w_f3)
          3'd0: w_type = OP_BEQ;
          3'd1: w_type = OP_BNE;
          3'd4: w_type = OP_BLT;
          3'd5: w_type = OP_BGE;
          3'd6: w_type = OP_BLTU;
          3'd7: w_type = OP_BGEU;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_imm = w_imm_i; w_bad = 1'b0;
        case (w_f3)
          3'd0: w_type = OP_LB;
          3'd1: w_type = OP_LH;
          3'd2: w_type = OP_LW;
          3'd4: w_type = OP_LBU;
          3'd5: w_type = OP_LHU;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_imm = w_imm_s; w_bad = 1'b0;
        case (w_f3)
          3'd0: w_type = OP_SB;
          3'd1: w_type = OP_SH;
          3'd2: w_type = OP_SW;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        w_imm = w_imm_i; w_bad = 1'b0;
        case (w_f3)
          3'd0: w_type = OP_ADDI;
          3'd2: w_type = OP_SLTI;
          3'd3: w_type = OP_SLTIU;
          3'd4: w_type = OP_XORI;
          3'd6: w_type = OP_ORI;
          3'd7: w_type = OP_ANDI;
          3'd1: begin
            w_imm = w_imm_sh;
            if (w_f7 == F7_BASE) w_type = OP_SLLI;
            else                 w_bad  = 1'b1;
          end
          default: begin
            w_imm = w_imm_sh;
            if      (w_f7 == F7_BASE) w_type = OP_SRLI;
            else if (w_f7 == F7_ALT)  w_type = OP_SRAI;
            else                      w_bad  = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        w_bad = 1'b0;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'd0: w_type = OP_ADD;
            3'd1: w_type = OP_SLL;
            3'd2: w_type = OP_SLT;
            3'd3: w_type = OP_SLTU;
            3'd4: w_type = OP_XOR;
            3'd5: w_type = OP_SRL;
            3'd6: w_type = OP_OR;
            default: w_type = OP_AND;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == 3'd0) begin
          w_type = OP_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == 3'd5) begin
          w_type = OP_SRA;
        end else begin
          w_bad = 1'b1;
        end
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    o_rd        = i_inst[11:7];
    o_rs        = i_inst[19:15];
    o_rt        = i_inst[24:20];
    o_type      = w_bad ? OP_ILLEGAL : w_type;
    o_imm       = w_bad ? 32'd0 : w_imm;
    o_is_ls     = !w_bad && (w_opc == OPC_LOAD || w_opc == OPC_STORE);
    o_writes_rd = !w_bad && w_opc != OPC_STORE && w_opc != OPC_BRANCH
                  && i_inst[11:7] != ZERO_REG;
`ifdef DECODE_ILLEGAL_TRAP_EN
    o_illegal   = w_bad;
`else
    // Unknown encodings are replaced by a NOP (ADDI x0,x0,0) bound for RS.
    o_illegal   = 1'b0;
    if (w_bad) begin
      o_type = OP_ADDI;
      o_rd   = ZERO_REG;
      o_rs   = ZERO_REG;
      o_rt   = ZERO_REG;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/decode_issue_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : decode_issue_queue                                          |
// | Purpose  : IQ_DEPTH-entry circular queue of fetched RV32I instructions;|
// |            decodes the head and dispatches at most one per cycle to    |
// |            ROB+RS or ROB+LSB. in_flush empties the queue in one cycle. |
// | Ports    : clk_in, rst_in (sync, active-high); bus (slave modport of   |
// |            decode_issue_queue_if): fetch offer/full, backend full      |
// |            flags, ROB tail tag, dispatch enables and decoded fields.   |
// | Config   : DECODE_ILLEGAL_TRAP_EN - unknown head goes to ROB only as   |
// |            ILLEGAL and the queue halts fetch until in_flush.           |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int IQ_DEPTH  = 8,
  parameter int ROB_IDX_W = 4,
  parameter int OP_W      = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  decode_issue_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t        slot_q [IQ_DEPTH];
  iq_entry_t        slot_d [IQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  iq_entry_t   w_head;
  op_e         w_type;
  logic [31:0] w_imm;
  logic [4:0]  w_rd, w_rs, w_rt;
  logic        w_is_ls, w_writes_rd, w_illegal;
  logic        w_not_empty, w_full, w_halt, w_target_full, w_dispatch, w_enqueue;

  assign w_head = slot_q[head_q];

  inst_field_decode u_decode (
    .i_inst      (w_head.inst),
    .o_type      (w_type),
    .o_imm       (w_imm),
    .o_rd        (w_rd),
    .o_rs        (w_rs),
    .o_rt        (w_rt),
    .o_is_ls     (w_is_ls),
    .o_writes_rd (w_writes_rd),
    .o_illegal   (w_illegal)
  );

  // Full comes from the registered count, so a same-cycle dequeue never
  // makes room for that cycle's offer.
  assign w_not_empty   = (count_q != '0);
  assign w_full        = (count_q == CNT_W'(IQ_DEPTH)) | w_halt;
  // An illegal head goes to the ROB only, so no RS/LSB space is needed.
  assign w_target_full = w_is_ls ? bus.in_lsb_full : (w_illegal ? 1'b0 : bus.in_rs_full);
  assign w_dispatch    = w_not_empty & bus.rdy_in & !bus.in_flush & !rst_in
                         & !bus.in_rob_full & !w_target_full;
  assign w_enqueue     = bus.in_fetch_valid & !w_full & !bus.in_flush
                         & bus.rdy_in & !rst_in;

  always_comb begin
    slot_d  = slot_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.in_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_enqueue) begin
        slot_d[tail_q] = '{inst: bus.in_fetch_inst, pc: bus.in_fetch_pc,
                           predict: bus.in_fetch_predict};
        tail_d = tail_q + PTR_W'(1);
      end
      if (w_dispatch) head_d = head_q + PTR_W'(1);
      case ({w_enqueue, w_dispatch})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (bus.in_flush)                  state_d = ST_RUN;
    else if (w_dispatch && w_illegal)  state_d = ST_HALT;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  assign w_halt = (state_q == ST_HALT);
`else
  assign w_halt = 1'b0;
`endif

  assign bus.out_fetch_full        = w_full;
  assign bus.out_rob_assign_enable = w_dispatch;
  assign bus.out_rs_assign_enable  = w_dispatch & !w_is_ls & !w_illegal;
  assign bus.out_lsb_assign_enable = w_dispatch & w_is_ls;
  assign bus.out_reg_write_enable  = w_dispatch & w_writes_rd;
  assign bus.out_type              = OP_W'(w_type);
  assign bus.out_imm               = w_imm;
  assign bus.out_pc                = w_head.pc;
  assign bus.out_predict           = w_head.predict;
  assign bus.out_rd                = w_rd;
  assign bus.out_rs                = w_rs;
  assign bus.out_rt                = w_rt;
  assign bus.out_reorder           = ROB_IDX_W'(bus.in_rob_tail);
  // Stale slot contents behind an empty queue must not raise the flag.
  assign bus.out_illegal           = w_illegal & w_not_empty;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_decode_issue_queue                                       |
// | Purpose  : Self-checking bench for decode_issue_queue: directed        |
// |            instruction table with hand-decoded fields, a queue-level   |
// |            reference model checked every cycle, and literal checks.    |
// | Config   : DECODE_ILLEGAL_TRAP_EN selects trap-build expectations.     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_decode_issue_queue;
  import decode_issue_queue_pkg::*;

  localparam int IQ_DEPTH = 8;

  typedef struct {
    logic [31:0] inst;
    op_e         ty;
    logic [31:0] imm;
    logic [4:0]  rd, rs, rt;
    bit          ls, wr, ill;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        pred;
  } mq_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_issue_queue_if #(.ROB_IDX_W(4), .OP_W(6)) bus ();

  decode_issue_queue #(.IQ_DEPTH(IQ_DEPTH), .ROB_IDX_W(4), .OP_W(6)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  vec_t tbl [12];
  mq_t  mq [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_idx = 0;
  int   seq     = 0;
  bit   m_halt  = 1'b0;
  int   m_n;
  vec_t m_h;
  bit   m_full, m_enq, m_disp, m_tfull;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_offer(input int idx);
    cur_idx                = idx;
    bus.in_fetch_valid     = 1'b1;
    bus.in_fetch_inst      = tbl[idx].inst;
    bus.in_fetch_pc        = 32'h1000 + 32'(seq) * 4;
    bus.in_fetch_predict   = seq[0];
    seq++;
  endtask

  // Reference model: a queue of table indices; outputs follow from the head
  // entry's hand-decoded fields and the dispatch/enqueue rules.
  always begin : p_compare
    @(negedge clk);
    #4;
    if (rst) begin
      mq.delete();
      m_halt = 1'b0;
    end else begin
      m_n     = mq.size();
      m_full  = (m_n == IQ_DEPTH) || m_halt;
      m_enq   = bus.in_fetch_valid && !m_full && !bus.in_flush && bus.rdy_in;
      if (m_n > 0) m_h = tbl[mq[0].idx];
      else         m_h = '{32'h0, OP_ILLEGAL, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
      m_tfull = m_h.ls ? bus.in_lsb_full : (m_h.ill ? 1'b0 : bus.in_rs_full);
      m_disp  = (m_n > 0) && bus.rdy_in && !bus.in_flush && !bus.in_rob_full && !m_tfull;

      chk("rob_en",  32'(bus.out_rob_assign_enable), 32'(m_disp));
      chk("rs_en",   32'(bus.out_rs_assign_enable),  32'(m_disp && !m_h.ls && !m_h.ill));
      chk("lsb_en",  32'(bus.out_lsb_assign_enable), 32'(m_disp && m_h.ls));
      chk("reg_wr",  32'(bus.out_reg_write_enable),  32'(m_disp && m_h.wr));
      chk("full",    32'(bus.out_fetch_full),        32'(m_full));
      chk("illegal", 32'(bus.out_illegal),           32'((m_n > 0) && m_h.ill));
      chk("reorder", 32'(bus.out_reorder),           32'(bus.in_rob_tail));
      if (m_n > 0) begin
        chk("type", 32'(bus.out_type),    32'(m_h.ty));
        chk("rd",   32'(bus.out_rd),      32'(m_h.rd));
        chk("rs",   32'(bus.out_rs),      32'(m_h.rs));
        chk("rt",   32'(bus.out_rt),      32'(m_h.rt));
        chk("pc",   bus.out_pc,           mq[0].pc);
        chk("pred", 32'(bus.out_predict), 32'(mq[0].pred));
        if (!m_h.ill) chk("imm", bus.out_imm, m_h.imm);
      end

      if (bus.in_flush) begin
        mq.delete();
        m_halt = 1'b0;
      end else begin
        if (m_disp) begin
          if (m_h.ill) m_halt = 1'b1;
          void'(mq.pop_front());
        end
        if (m_enq) mq.push_back('{cur_idx, bus.in_fetch_pc, bus.in_fetch_predict});
      end
    end
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : p_drive
    int lst [9];
    lst = '{0, 3, 4, 5, 6, 7, 8, 10, 11};

    //            inst          type        imm           rd     rs     rt     ls wr ill
    tbl[0]  = '{32'h00500093, OP_ADDI,  32'd5,        5'd1,  5'd0,  5'd5,  0, 1, 0}; // addi x1,x0,5
    tbl[1]  = '{32'h0020A423, OP_SW,    32'd8,        5'd8,  5'd1,  5'd2,  1, 0, 0}; // sw x2,8(x1)
    tbl[2]  = '{32'h0040A183, OP_LW,    32'd4,        5'd3,  5'd1,  5'd4,  1, 1, 0}; // lw x3,4(x1)
    tbl[3]  = '{32'h002082B3, OP_ADD,   32'd0,        5'd5,  5'd1,  5'd2,  0, 1, 0}; // add x5,x1,x2
    tbl[4]  = '{32'h40418333, OP_SUB,   32'd0,        5'd6,  5'd3,  5'd4,  0, 1, 0}; // sub x6,x3,x4
    tbl[5]  = '{32'h123453B7, OP_LUI,   32'h12345000, 5'd7,  5'd8,  5'd3,  0, 1, 0}; // lui x7,0x12345
    tbl[6]  = '{32'hFE208CE3, OP_BEQ,   32'hFFFFFFF8, 5'd25, 5'd1,  5'd2,  0, 0, 0}; // beq x1,x2,-8
    tbl[7]  = '{32'h010000EF, OP_JAL,   32'd16,       5'd1,  5'd0,  5'd16, 0, 1, 0}; // jal x1,16
    tbl[8]  = '{32'h40345413, OP_SRAI,  32'd3,        5'd8,  5'd8,  5'd3,  0, 1, 0}; // srai x8,x8,3
`ifdef DECODE_ILLEGAL_TRAP_EN
    tbl[9]  = '{32'hFFFFFFFF, OP_ILLEGAL, 32'd0,      5'd31, 5'd31, 5'd31, 0, 0, 1};
`else
    tbl[9]  = '{32'hFFFFFFFF, OP_ADDI,  32'd0,        5'd0,  5'd0,  5'd0,  0, 0, 0}; // becomes NOP
`endif
    tbl[10] = '{32'h00001517, OP_AUIPC, 32'h00001000, 5'd10, 5'd0,  5'd0,  0, 1, 0}; // auipc x10,1
    tbl[11] = '{32'hFFF0E013, OP_ORI,   32'hFFFFFFFF, 5'd0,  5'd1,  5'd31, 0, 0, 0}; // ori x0,x1,-1

    bus.rdy_in = 1'b1;      bus.in_flush = 1'b0;
    bus.in_fetch_valid = 1'b0; bus.in_fetch_inst = 32'h0;
    bus.in_fetch_pc = 32'h0; bus.in_fetch_predict = 1'b0;
    bus.in_rob_full = 1'b0; bus.in_rs_full = 1'b0; bus.in_lsb_full = 1'b0;
    bus.in_rob_tail = 4'd3;

    // 1: reset state, then a single addi dispatches one cycle after enqueue
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_full",    32'(bus.out_fetch_full), 32'd0);
    chk("rst_rob_en",  32'(bus.out_rob_assign_enable), 32'd0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
    @(negedge clk);
    set_offer(0);
    #4;
    chk("t1_same_cycle_rob_en", 32'(bus.out_rob_assign_enable), 32'd0);
    @(negedge clk);
    bus.in_fetch_valid = 1'b0;
    #4;
    chk("t1_rs_en",   32'(bus.out_rs_assign_enable), 32'd1);
    chk("t1_rob_en",  32'(bus.out_rob_assign_enable), 32'd1);
    chk("t1_imm",     bus.out_imm, 32'd5);
    chk("t1_rd",      32'(bus.out_rd), 32'd1);
    chk("t1_reg_wr",  32'(bus.out_reg_write_enable), 32'd1);
    chk("t1_reorder", 32'(bus.out_reorder), 32'd3);
    @(negedge clk);

    // 2: RS blocked, fill past capacity, then drain in order with wrap
    bus.in_rs_full = 1'b1;
    for (int k = 0; k < 9; k++) begin
      set_offer(lst[k]);
      if (k == 8) begin
        #4;
        chk("t2_full_after_8", 32'(bus.out_fetch_full), 32'd1);
      end
      @(negedge clk);
    end
    bus.in_rs_full = 1'b0;
    #4;
    chk("t2_release_rs_en", 32'(bus.out_rs_assign_enable), 32'd1);
    chk("t2_release_imm",   bus.out_imm, 32'd5);
    chk("t2_still_full",    32'(bus.out_fetch_full), 32'd1);
    @(negedge clk);
    #4;
    chk("t2_room_again", 32'(bus.out_fetch_full), 32'd0);
    @(negedge clk);
    bus.in_fetch_valid = 1'b0;
    repeat (10) @(negedge clk);

    // 3: store at head waits on LSB, then dispatches to LSB only
    set_offer(1);
    @(negedge clk);
    set_offer(2);
    bus.in_lsb_full = 1'b1;
    #4;
    chk("t3_blocked_lsb", 32'(bus.out_lsb_assign_enable), 32'd0);
    chk("t3_blocked_rob", 32'(bus.out_rob_assign_enable), 32'd0);
    @(negedge clk);
    bus.in_fetch_valid = 1'b0;
    @(negedge clk);
    bus.in_lsb_full = 1'b0;
    #4;
    chk("t3_lsb_en", 32'(bus.out_lsb_assign_enable), 32'd1);
    chk("t3_rs_en",  32'(bus.out_rs_assign_enable), 32'd0);
    chk("t3_reg_wr", 32'(bus.out_reg_write_enable), 32'd0);
    chk("t3_imm",    bus.out_imm, 32'd8);
    @(negedge clk);
    #4;
    chk("t3_load_reg_wr", 32'(bus.out_reg_write_enable), 32'd1);
    @(negedge clk);

    // 4: flush with five queued entries and a simultaneous fetch offer
    bus.in_rs_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_offer(lst[k]);
      @(negedge clk);
    end
    set_offer(8);
    bus.in_flush = 1'b1;
    #4;
    chk("t4_flush_rob_en", 32'(bus.out_rob_assign_enable), 32'd0);
    @(negedge clk);
    bus.in_flush = 1'b0;
    bus.in_fetch_valid = 1'b0;
    bus.in_rs_full = 1'b0;
    #4;
    chk("t4_empty_rob_en", 32'(bus.out_rob_assign_enable), 32'd0);
    chk("t4_empty_rs_en",  32'(bus.out_rs_assign_enable), 32'd0);
    @(negedge clk);
    #4;
    chk("t4_offer_dropped", 32'(bus.out_rob_assign_enable), 32'd0);
    @(negedge clk);

    // 5: unknown encoding at head
    set_offer(9);
    @(negedge clk);
    bus.in_fetch_valid = 1'b0;
    #4;
    chk("t5_rob_en", 32'(bus.out_rob_assign_enable), 32'd1);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("t5_rs_en",   32'(bus.out_rs_assign_enable), 32'd0);
    chk("t5_lsb_en",  32'(bus.out_lsb_assign_enable), 32'd0);
    chk("t5_illegal", 32'(bus.out_illegal), 32'd1);
    chk("t5_type",    32'(bus.out_type), 32'(OP_ILLEGAL));
`else
    chk("t5_nop_rs_en",  32'(bus.out_rs_assign_enable), 32'd1);
    chk("t5_nop_type",   32'(bus.out_type), 32'(OP_ADDI));
    chk("t5_nop_rd",     32'(bus.out_rd), 32'd0);
    chk("t5_nop_reg_wr", 32'(bus.out_reg_write_enable), 32'd0);
`endif
    @(negedge clk);
    set_offer(0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    #4;
    chk("t5_halt_full", 32'(bus.out_fetch_full), 32'd1);
`endif
    repeat (2) @(negedge clk);
    bus.in_fetch_valid = 1'b0;
    bus.in_flush = 1'b1;
    @(negedge clk);
    bus.in_flush = 1'b0;
    set_offer(0);
    @(negedge clk);
    bus.in_fetch_valid = 1'b0;
    #4;
    chk("t5_after_flush_rs_en", 32'(bus.out_rs_assign_enable), 32'd1);
    @(negedge clk);

    // 6: full queue frozen by rdy_in, then dispatch alongside a refused offer
    bus.in_rob_tail = 4'd9;
    bus.in_rs_full = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_offer(lst[k]);
      @(negedge clk);
    end
    bus.rdy_in = 1'b0;
    bus.in_rs_full = 1'b0;
    set_offer(11);
    repeat (3) begin
      #4;
      chk("t6_frozen_rob_en", 32'(bus.out_rob_assign_enable), 32'd0);
      chk("t6_frozen_full",   32'(bus.out_fetch_full), 32'd1);
      @(negedge clk);
    end
    bus.rdy_in = 1'b1;
    #4;
    chk("t6_dispatch_rs_en", 32'(bus.out_rs_assign_enable), 32'd1);
    chk("t6_offer_refused",  32'(bus.out_fetch_full), 32'd1);
    @(negedge clk);
    #4;
    chk("t6_slot_freed", 32'(bus.out_fetch_full), 32'd0);
    @(negedge clk);
    bus.in_fetch_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
